vliw_operand_xbar: RTL and testbench
====================================

Name: vliw_operand_xbar

Overview:
Parametrised operand storage and routing block for the VLIW datapath. It has one write port per functional unit (load, neg, add, mul, and any future units), and each write port owns a private bank. Any number of operand read ports can read any bank through a global address space. Offset 0 of every bank aliases a shared z register. The block replaces the per-unit, per-operand replicated register files with a single parametrised crossbar. It adds a defined z-write priority, per-entry valid tracking, bulk clear and optional write-to-read bypass.

Parameters:
DATA_W, 27, operand width in bits
NUM_WR, 4, number of write ports (one per unit, port p owns bank p)
NUM_RD, 5, number of read ports (one per operand input)
BANK_DEPTH, 256, entries per bank; power of two, >= 2
OFF_W, clog2(BANK_DEPTH), localparam, bank offset width
ADDR_W, clog2(NUM_WR*BANK_DEPTH), localparam, global read address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clear  in  1  single-cycle pulse; invalidates all entries and zeroes z
wr_en  in  NUM_WR  per-port write enable
wr_off  in  NUM_WR*OFF_W  per-port bank offset; port p occupies bits [p*OFF_W +: OFF_W]
wr_data  in  NUM_WR*DATA_W  per-port write data
rd_en  in  NUM_RD  per-port read strobe
rd_addr  in  NUM_RD*ADDR_W  global read address: bank = addr / BANK_DEPTH, offset = addr % BANK_DEPTH
rd_data  out  NUM_RD*DATA_W  registered read data
rd_valid  out  NUM_RD  pulses 1 cycle after the matching rd_en

Behaviour:
- Clock clk. Reset reset is synchronous and active-high.
- Reset values:
  - rd_data = 0, rd_valid = 0.
  - z = 0.
  - All valid bits = 0.
  - Bank RAM contents are not cleared. Valid bits mask them.
- Writes, wr_en[p]=1, offset != 0:
  - bank[p][offset] <= data, valid[p][offset] <= 1.
  - Write ports never conflict, because each bank has exactly one writer.
- Writes, offset == 0:
  - Updates z only. The bank entry is not written.
  - Several ports writing offset 0 in the same cycle: the lowest-index port wins; the others are dropped.
- Reads:
  - 1-cycle latency. rd_en[r] in cycle N gives rd_data[r] and rd_valid[r]=1 in cycle N+1.
  - With rd_en[r]=0, rd_valid[r]=0 and rd_data[r] holds its last value.
- Read data selection, applied in order:
  - offset == 0 → z.
  - bank index >= NUM_WR (out-of-range address) → 0.
  - valid bit clear (never written since reset/clear) → 0.
  - Otherwise → bank contents.
- Same-cycle write and read of the same location (including z) is read-before-write: the read returns the old value.
- Read ports are independent. Any number of ports may read the same address in the same cycle.
- clear:
  - Next cycle, all valid bits = 0 and z = 0.
  - rd_data and rd_valid are unaffected, so a read issued in the same cycle as clear returns pre-clear data.
  - Writes in the same cycle as clear are discarded.
- reset has priority over clear and over writes. A read in flight during reset produces rd_valid=0 in the next cycle.
- Implementation: valid bits in flops; banks may be RAM with a registered read (one copy per read port, or multi-pumped); z in flops.

Optional Feature:
- Macro: VLIW_XBAR_BYPASS_EN.
- Defined: a read to the same location as a same-cycle write returns the new write data (write-to-read forwarding).
  - For z, forwarding uses the priority-winning data.
  - clear still wins: a forwarded write in the clear cycle returns 0.
- Undefined: read-before-write as specified above.

Test Plan:
- Reset, then read addr 5 and addr 0 → rd_valid=1 next cycle, rd_data=0 for both (unwritten entry, z=0).
- Port 2 writes off 7, data 27'h123 (global addr 519); read addr 519 next cycle → 27'h123. Read addr 7 → 0 (bank 0 unwritten).
- Ports 1 and 3 both write off 0 (data 27'hAA, 27'hBB) in the same cycle; read addr 768 → 27'hAA. Read addr 256 → 27'hAA (z aliases every bank).
- Write addr 300 (port 1, off 44, 27'h55) with a same-cycle read of 300 → 0 without the macro, 27'h55 with VLIW_XBAR_BYPASS_EN. The next read → 27'h55 in both builds.
- Fill several entries and z, pulse clear → all subsequent reads return 0. Assert reset together with a write and an rd_en → write lost, rd_valid=0 next cycle.
- All 5 read ports read addr 519 simultaneously → all return 27'h123. Read addr 1023 with NUM_WR=3 → 0.

Source files
------------

// File: rtl/vliw_operand_xbar.sv
// vliw_operand_xbar: banked operand store with a global read crossbar.
// Each write port p owns bank p. Offset 0 of every bank aliases one shared z
// register. Valid bits mask bank RAM contents, which are never cleared.
// Optional build macro VLIW_XBAR_BYPASS_EN enables write-to-read forwarding.
//
// Read handshake: rd_en[r] is a strobe with no backpressure. rd_valid[r]
// pulses for exactly one cycle, one cycle after the strobe, together with
// rd_data[r]. Without a strobe, rd_data[r] holds its last value.
module vliw_operand_xbar #(
    parameter int DATA_W     = 27,
    parameter int NUM_WR     = 4,
    parameter int NUM_RD     = 5,
    parameter int BANK_DEPTH = 256,
    localparam int OFF_W     = $clog2(BANK_DEPTH),
    localparam int ADDR_W    = $clog2(NUM_WR * BANK_DEPTH),
    localparam int BANK_W    = ADDR_W - OFF_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*OFF_W-1:0]    wr_off,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid
);

    logic [DATA_W-1:0]     bank_mem [NUM_WR][BANK_DEPTH];
    logic [BANK_DEPTH-1:0] valid_q  [NUM_WR];
    logic [DATA_W-1:0]     z_q;

    logic [OFF_W-1:0]      w_off   [NUM_WR];
    logic [DATA_W-1:0]     w_data  [NUM_WR];
    logic [NUM_WR-1:0]     bank_we;
    logic                  z_we;
    logic [DATA_W-1:0]     z_wdata;

    logic [OFF_W-1:0]      rd_off  [NUM_RD];
    logic [BANK_W-1:0]     rd_bank [NUM_RD];
    logic [DATA_W-1:0]     rd_next [NUM_RD];
    logic [DATA_W-1:0]     rd_data_q [NUM_RD];
    logic [NUM_RD-1:0]     rd_valid_q;

    // Unpack write ports; offset 0 targets z, never the bank entry.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            w_off[p]   = wr_off[p*OFF_W +: OFF_W];
            w_data[p]  = wr_data[p*DATA_W +: DATA_W];
            bank_we[p] = wr_en[p] && (w_off[p] != '0);
        end
    end

    // z write arbitration: scanning high to low leaves the lowest port's data.
    always_comb begin
        z_we    = 1'b0;
        z_wdata = '0;
        for (int p = NUM_WR - 1; p >= 0; p--) begin
            if (wr_en[p] && (w_off[p] == '0)) begin
                z_we    = 1'b1;
                z_wdata = w_data[p];
            end
        end
    end

    // Bank RAM write; reset and clear both discard the cycle's writes.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_WR; p++) begin
            if (!reset && !clear && bank_we[p]) begin
                bank_mem[p][w_off[p]] <= w_data[p];
            end
        end
    end

    // Valid bits and z: reset beats clear, clear beats writes.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int p = 0; p < NUM_WR; p++) begin
                valid_q[p] <= '0;
            end
            z_q <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (bank_we[p]) begin
                    valid_q[p][w_off[p]] <= 1'b1;
                end
            end
            if (z_we) begin
                z_q <= z_wdata;
            end
        end
    end

    // Split each global read address into bank index and bank offset.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_off[r]  = rd_addr[r*ADDR_W +: OFF_W];
            rd_bank[r] = rd_addr[r*ADDR_W + OFF_W +: BANK_W];
        end
    end

    // Read data selection: z alias, out-of-range bank, invalid entry, bank.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_next[r] = '0;
            if (rd_off[r] == '0) begin
                rd_next[r] = z_q;
            end else if (int'(rd_bank[r]) >= NUM_WR) begin
                rd_next[r] = '0;
            end else if (!valid_q[rd_bank[r]][rd_off[r]]) begin
                rd_next[r] = '0;
            end else begin
                rd_next[r] = bank_mem[rd_bank[r]][rd_off[r]];
            end
`ifdef VLIW_XBAR_BYPASS_EN
            // Forward same-cycle write data; a clear in that cycle forces 0.
            if (rd_off[r] == '0) begin
                if (z_we) begin
                    rd_next[r] = clear ? '0 : z_wdata;
                end
            end else if (int'(rd_bank[r]) < NUM_WR) begin
                if (bank_we[rd_bank[r]] && (w_off[rd_bank[r]] == rd_off[r])) begin
                    rd_next[r] = clear ? '0 : w_data[rd_bank[r]];
                end
            end
`endif
        end
    end

    // Registered read port: one-cycle latency, data held when not strobed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= '0;
            for (int r = 0; r < NUM_RD; r++) begin
                rd_data_q[r] <= '0;
            end
        end else begin
            rd_valid_q <= rd_en;
            for (int r = 0; r < NUM_RD; r++) begin
                if (rd_en[r]) begin
                    rd_data_q[r] <= rd_next[r];
                end
            end
        end
    end

    // Pack read outputs.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data[r*DATA_W +: DATA_W] = rd_data_q[r];
        end
    end

    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_vliw_operand_xbar.sv
// Bench for vliw_operand_xbar: default instance (4 banks, 5 read ports) plus
// a 3-bank instance for out-of-range addresses. Expected read results are
// queued when a read is issued; a negedge monitor pops and compares them.
module tb_vliw_operand_xbar;

  logic clk = 1'b0;
  logic reset;
  logic clear;

  logic [3:0]   wr_en;
  logic [31:0]  wr_off;
  logic [107:0] wr_data;
  logic [4:0]   rd_en;
  logic [49:0]  rd_addr;
  logic [134:0] rd_data;
  logic [4:0]   rd_valid;

  logic [2:0]   wr_en3;
  logic [23:0]  wr_off3;
  logic [80:0]  wr_data3;
  logic [0:0]   rd_en3;
  logic [9:0]   rd_addr3;
  logic [26:0]  rd_data3;
  logic [0:0]   rd_valid3;

  int cyc = 0;
  int vectors = 0;
  int fails = 0;

  // {cycle[46:31], inst[30], port[29:27], data[26:0]}
  logic [46:0] exp_q[$];

  vliw_operand_xbar u_dut (
    .clk(clk), .reset(reset), .clear(clear),
    .wr_en(wr_en), .wr_off(wr_off), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  vliw_operand_xbar #(.NUM_WR(3), .NUM_RD(1)) u_dut3 (
    .clk(clk), .reset(reset), .clear(clear),
    .wr_en(wr_en3), .wr_off(wr_off3), .wr_data(wr_data3),
    .rd_en(rd_en3), .rd_addr(rd_addr3),
    .rd_data(rd_data3), .rd_valid(rd_valid3)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
    reset = 1'b0; clear = 1'b0;
    wr_en = '0; rd_en = '0;
    wr_en3 = '0; rd_en3 = '0;
  endtask

  task automatic set_wr(input int p, input logic [7:0] off, input logic [26:0] d);
    wr_en[p] = 1'b1;
    wr_off[p*8 +: 8] = off;
    wr_data[p*27 +: 27] = d;
  endtask

  task automatic set_rd(input int r, input logic [9:0] addr, input logic [26:0] e);
    rd_en[r] = 1'b1;
    rd_addr[r*10 +: 10] = addr;
    exp_q.push_back({16'(cyc + 1), 1'b0, 3'(r), e});
  endtask

  task automatic set_wr3(input int p, input logic [7:0] off, input logic [26:0] d);
    wr_en3[p] = 1'b1;
    wr_off3[p*8 +: 8] = off;
    wr_data3[p*27 +: 27] = d;
  endtask

  task automatic set_rd3(input logic [9:0] addr, input logic [26:0] e);
    rd_en3[0] = 1'b1;
    rd_addr3 = addr;
    exp_q.push_back({16'(cyc + 1), 1'b1, 3'd0, e});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [46:0] e;
    logic [4:0]  m0;
    logic        m3;
    logic [26:0] got;
    logic        v;
    int          pi;
    m0 = '0;
    m3 = 1'b0;
    while (exp_q.size() > 0 && int'(exp_q[0][46:31]) <= cyc) begin
      e = exp_q.pop_front();
      pi = int'(e[29:27]);
      if (e[30]) begin
        got = rd_data3; v = rd_valid3[0]; m3 = 1'b1;
      end else begin
        got = rd_data[pi*27 +: 27]; v = rd_valid[pi]; m0[pi] = 1'b1;
      end
      vectors++;
      if (int'(e[46:31]) != cyc || v !== 1'b1 || got !== e[26:0]) begin
        fails++;
        $display("FAIL read inst%0d port%0d cyc%0d: got valid=%b data=%h, want valid=1 data=%h",
                 e[30], pi, cyc, v, got, e[26:0]);
      end
    end
    if (cyc > 1) begin
      vectors++;
      if (rd_valid !== m0 || rd_valid3[0] !== m3) begin
        fails++;
        $display("FAIL rd_valid cyc%0d: got %b/%b, want %b/%b", cyc, rd_valid, rd_valid3, m0, m3);
      end
    end
  end

  localparam logic [26:0] BYP_300 =
`ifdef VLIW_XBAR_BYPASS_EN
    27'h55;
`else
    27'h0;
`endif
  localparam logic [26:0] BYP_Z =
`ifdef VLIW_XBAR_BYPASS_EN
    27'h11;
`else
    27'hAA;
`endif
  localparam logic [26:0] CLR_Z =
`ifdef VLIW_XBAR_BYPASS_EN
    27'h0;
`else
    27'h11;
`endif

  // directed stimulus
  initial begin
    reset = 1'b1; clear = 1'b0;
    wr_en = '0; wr_off = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
    wr_en3 = '0; wr_off3 = '0; wr_data3 = '0; rd_en3 = '0; rd_addr3 = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (rd_data !== '0 || rd_valid !== '0) begin
      fails++;
      $display("FAIL reset_state: got data=%h valid=%b, want 0/0", rd_data, rd_valid);
    end

    // unwritten entry and z after reset
    next_cycle(); set_rd(0, 10'd5, 27'h0); set_rd(1, 10'd0, 27'h0);
    // bank write and cross-bank read
    next_cycle(); set_wr(2, 8'd7, 27'h123);
    next_cycle(); set_rd(0, 10'd519, 27'h123); set_rd(1, 10'd7, 27'h0);
    // z priority and aliasing
    next_cycle(); set_wr(1, 8'd0, 27'hAA); set_wr(3, 8'd0, 27'hBB);
    next_cycle(); set_rd(0, 10'd768, 27'hAA); set_rd(1, 10'd256, 27'hAA); set_rd(2, 10'd0, 27'hAA);
    // same-cycle write/read of a bank entry
    next_cycle(); set_wr(1, 8'd44, 27'h55); set_rd(0, 10'd300, BYP_300);
    next_cycle(); set_rd(0, 10'd300, 27'h55);
    // same-cycle z write (ports 0 and 2) and read
    next_cycle(); set_wr(0, 8'd0, 27'h11); set_wr(2, 8'd0, 27'h22); set_rd(1, 10'd512, BYP_Z);
    next_cycle(); set_rd(1, 10'd0, 27'h11);
    // all read ports on one address, then hold
    next_cycle(); for (int r = 0; r < 5; r++) set_rd(r, 10'd519, 27'h123);
    next_cycle();
    next_cycle();
    vectors++;
    if (rd_data[26:0] !== 27'h123 || rd_valid !== '0) begin
      fails++;
      $display("FAIL hold: got data=%h valid=%b, want 123/0", rd_data[26:0], rd_valid);
    end
    // clear with same-cycle writes and reads
    clear = 1'b1;
    set_wr(3, 8'd9, 27'h77); set_wr(1, 8'd0, 27'h66);
    set_rd(0, 10'd519, 27'h123); set_rd(1, 10'd777, 27'h0); set_rd(2, 10'd0, CLR_Z);
    next_cycle();
    set_rd(0, 10'd519, 27'h0); set_rd(1, 10'd300, 27'h0);
    set_rd(2, 10'd0, 27'h0); set_rd(3, 10'd777, 27'h0);
    // reset with write and read in flight
    next_cycle(); set_wr(2, 8'd7, 27'h321); set_wr(0, 8'd0, 27'h44);
    reset = 1'b1; rd_en[0] = 1'b1; rd_addr[9:0] = 10'd519;
    next_cycle(); set_rd(0, 10'd519, 27'h0); set_rd(1, 10'd0, 27'h0);
    next_cycle(); set_wr(2, 8'd7, 27'h2AB);
    next_cycle(); set_rd(4, 10'd519, 27'h2AB);
    // 3-bank instance: out-of-range bank and z alias through it
    next_cycle(); set_wr3(2, 8'd255, 27'h3FF); set_wr3(0, 8'd0, 27'h5); set_rd3(10'd1023, 27'h0);
    next_cycle(); set_rd3(10'd767, 27'h3FF);
    next_cycle(); set_rd3(10'd1023, 27'h0);
    next_cycle(); set_rd3(10'd768, 27'h5);
    repeat (3) next_cycle();

    vectors++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
